// File: rtl/alu_pkg.sv
// Shared types and constants for the iterative divider beside the ALU.
package alu_pkg;

    localparam int unsigned DIV_WIDTH   = 32;
    localparam int unsigned DIV_LATENCY = DIV_WIDTH + 2;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ITER  = 2'b01,
        FIXUP = 2'b10,
        DONE  = 2'b11
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial subtract of the shifted partial remainder, restore on borrow.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_shift_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH:0] trial;

    // rem_shift_in < 2*divisor always holds, so bit WIDTH of the trial is its exact sign.
    always_comb begin
        trial    = rem_shift_in - {1'b0, divisor_in};
        q_bit    = ~trial[WIDTH];
        next_rem = q_bit ? trial[WIDTH-1:0] : rem_shift_in[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU; one quotient bit per cycle.
module seq_divider
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             start_in,
    input  logic [1:0]       op_in,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] result_out
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             is_rem_q, is_rem_d;
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;

    div_op_t          op;
    logic             signed_op;
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic             div_zero, overflow;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem_shift_in({rem_q, quot_q[WIDTH-1]}),
        .divisor_in  (divisor_q),
        .next_rem    (step_rem),
        .q_bit       (step_q)
    );

    always_comb begin
        op        = div_op_t'(op_in);
        signed_op = (op == DIV) || (op == REM);
        sign_a    = signed_op & dividend_in[WIDTH-1];
        sign_b    = signed_op & divisor_in[WIDTH-1];
        abs_a     = sign_a ? -dividend_in : dividend_in;
        abs_b     = sign_b ? -divisor_in : divisor_in;
        div_zero  = (divisor_in == '0);
        overflow  = signed_op && (dividend_in == MinNeg) && (divisor_in == '1);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        divisor_d  = divisor_q;
        result_d   = result_q;
        is_rem_d   = is_rem_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;

        unique case (state_q)
            IDLE: begin
                if (start_in) begin
                    is_rem_d  = (op == REM) || (op == REMU);
                    divisor_d = abs_b;
                    cnt_d     = '0;
                    // Special cases preload final values and disable negation in FIXUP.
                    if (div_zero) begin
                        quot_d     = '1;
                        rem_d      = dividend_in;
                        neg_quot_d = 1'b0;
                        neg_rem_d  = 1'b0;
                        state_d    = FIXUP;
                    end else if (overflow) begin
                        quot_d     = MinNeg;
                        rem_d      = '0;
                        neg_quot_d = 1'b0;
                        neg_rem_d  = 1'b0;
                        state_d    = FIXUP;
                    end else begin
                        quot_d     = abs_a;
                        rem_d      = '0;
                        neg_quot_d = sign_a ^ sign_b;
                        neg_rem_d  = sign_a;
                        state_d    = ITER;
                    end
                end
            end
            ITER: begin
                rem_d  = step_rem;
                quot_d = {quot_q[WIDTH-2:0], step_q};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                if (is_rem_q) begin
                    result_d = neg_rem_q ? -rem_q : rem_q;
                end else begin
                    result_d = neg_quot_q ? -quot_q : quot_q;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            divisor_q  <= '0;
            result_q   <= '0;
            is_rem_q   <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            divisor_q  <= divisor_d;
            result_q   <= result_d;
            is_rem_q   <= is_rem_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
        end
    end

    always_comb begin
        busy_out   = (state_q != IDLE);
        done_out   = (state_q == DONE);
        result_out = result_q;
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected result and done cycle, monitor checks.
module tb_seq_divider;
    import alu_pkg::*;

    localparam int unsigned W = 32;
    localparam int NORM = 34;
    localparam int SPEC = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] result;

    seq_divider #(
        .WIDTH(W)
    ) dut (
        .clk_in     (clk),
        .reset_in   (reset),
        .start_in   (start),
        .op_in      (op),
        .dividend_in(a),
        .divisor_in (b),
        .busy_out   (busy),
        .done_out   (done),
        .result_out (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string        name;
        logic [W-1:0] res;
        int           due;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got pulse at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, "_result"}, result, e.res);
                check({e.name, "_cycle"}, cyc, e.due);
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got %0d pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic issue(input string name, input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] res, input int lat);
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        sb.push_back('{name, res, cyc + lat});
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 32'hdead_beef;
        b     = 32'h0000_0003;
        drain();
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);

        issue("divu_100_7",  DIVU, 32'd100, 32'd7, 32'd14, NORM);
        issue("remu_100_7",  REMU, 32'd100, 32'd7, 32'd2, NORM);
        issue("div_m7_2",    DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, NORM);
        issue("rem_m7_2",    REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, NORM);
        issue("rem_7_m2",    REM, 32'd7, 32'hFFFF_FFFE, 32'd1, NORM);
        issue("div_m7_m2",   DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, NORM);
        issue("div_x_0",     DIV, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, SPEC);
        issue("rem_x_0",     REM, 32'h1234_5678, 32'd0, 32'h1234_5678, SPEC);
        issue("divu_x_0",    DIVU, 32'h8765_4321, 32'd0, 32'hFFFF_FFFF, SPEC);
        issue("remu_x_0",    REMU, 32'h8765_4321, 32'd0, 32'h8765_4321, SPEC);
        issue("div_ovf",     DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC);
        issue("rem_ovf",     REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPEC);
        issue("divu_max_2",  DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, NORM);
        issue("divu_big",    DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, NORM);
        issue("remu_big",    REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, NORM);

        // start held high for the whole op, operands changed mid-flight
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = DIVU;
        a     = 32'd1000;
        b     = 32'd10;
        sb.push_back('{"held_start", 32'd100, cyc + NORM});
        for (int k = 0; k <= 35; k++) begin
            @(negedge clk);
            if (k == 0 || k == 35) check($sformatf("held_busy_%0d", k), {31'b0, busy}, 32'd0);
            else check($sformatf("held_busy_%0d", k), {31'b0, busy}, 32'd1);
            if (k == 5) begin
                a = 32'd5;
                b = 32'd5;
            end
            if (k == 34) start = 1'b0;
        end
        drain();
        repeat (5) @(posedge clk);

        // reset during ITER aborts with no done pulse and clears result
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = DIVU;
        a     = 32'd1000;
        b     = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        repeat (40) @(posedge clk);
        issue("after_abort", DIVU, 32'd9, 32'd3, 32'd3, NORM);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
